// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with registered read port, thresholds and sticky errors
module fifo_sync_param #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 3,
  parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic [DATA_WIDTH-1:0] FIFO_data_in,
  input  logic [CNT_WIDTH-1:0]  umbral_bajo,
  input  logic [CNT_WIDTH-1:0]  umbral_alto,
  input  logic                  clear_errors,
  output logic [DATA_WIDTH-1:0] FIFO_data_out,
  output logic                  FIFO_data_valid,
  output logic [CNT_WIDTH-1:0]  FIFO_count,
  output logic                  FIFO_empty,
  output logic                  FIFO_full,
  output logic                  FIFO_almost_empty,
  output logic                  FIFO_almost_full,
  output logic                  FIFO_overflow,
  output logic                  FIFO_underflow
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic rd_acc, wr_acc, wr_rej, rd_rej;

  // Occupancy alone decides full/empty, so pointers may wrap freely.
  assign FIFO_empty        = FIFO_count == '0;
  assign FIFO_full         = FIFO_count == CNT_WIDTH'(DEPTH);
  assign FIFO_almost_empty = !FIFO_empty && (FIFO_count <= umbral_bajo);
  assign FIFO_almost_full  = !FIFO_full && (FIFO_count >= umbral_alto);

  // A write into a full FIFO is legal only when a read frees a slot in the same cycle.
  assign rd_acc = Enable && read_enable && !FIFO_empty;
  assign wr_acc = Enable && write_enable && (!FIFO_full || rd_acc);
  assign wr_rej = Enable && write_enable && !wr_acc;
  assign rd_rej = Enable && read_enable && !rd_acc;

  // Storage is never cleared; a write coinciding with reset is dropped.
  always_ff @(posedge clk)
    if (wr_acc && !Reset) mem[wr_ptr] <= FIFO_data_in;

  // Pointers, count, registered read port and sticky error flags.
  always_ff @(posedge clk)
    if (Reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      FIFO_count      <= '0;
      FIFO_data_out   <= '0;
      FIFO_data_valid <= 1'b0;
      FIFO_overflow   <= 1'b0;
      FIFO_underflow  <= 1'b0;
    end else begin
      FIFO_data_valid <= rd_acc;
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_acc) begin
        rd_ptr        <= rd_ptr + ADDR_WIDTH'(1);
        FIFO_data_out <= mem[rd_ptr];
      end
      if (wr_acc != rd_acc)
        FIFO_count <= wr_acc ? FIFO_count + CNT_WIDTH'(1) : FIFO_count - CNT_WIDTH'(1);
      FIFO_overflow  <= wr_rej || (FIFO_overflow && !clear_errors);
      FIFO_underflow <= rd_rej || (FIFO_underflow && !clear_errors);
    end
endmodule
